seg_disp_arbiter: RTL
=====================

# seg_disp_arbiter

Time-shares the six-digit dynamic seven-segment display between three independent data sources. Each requester presents a 20-bit value, decimal-point mask and sign. The arbiter grants the display round-robin, holds each grant for a fixed dwell time, inserts a short blanked gap between owners, and drives the `data`/`point`/`sign`/`seg_en` inputs of `seg_dynamic` in place of a single `data_gen`.

## Interface
- `DWELL_MAX`, 26'd49_999_999: last count of a display slot; slot = DWELL_MAX+1 clocks (1 s at 50 MHz).
- `BLANK_MAX`, 16'd4_999: last count of the inter-owner blank gap; gap = BLANK_MAX+1 clocks.
- `sys_clk`  input  1  system clock, 50 MHz.
- `sys_rst`  input  1  reset; one clock; reset is asynchronous and active-high.
- `req`  input  3  per-source display request, level; bit i = source i.
- `data0`/`data1`/`data2`  input  20  value of source i, binary 0..999_999.
- `point0`/`point1`/`point2`  input  6  decimal-point mask of source i.
- `sign0`/`sign1`/`sign2`  input  1  negative flag of source i.
- `gnt`  output  3  one-hot current owner; 0 when none.
- `data`  output  20  to `seg_dynamic`.
- `point`  output  6  to `seg_dynamic`.
- `sign`  output  1  to `seg_dynamic`.
- `seg_en`  output  1  display enable to `seg_dynamic`.

## Operation
- States: IDLE, SHOW, BLANK. Reset: state IDLE, `gnt`=0, `data`=0, `point`=0, `sign`=0, `seg_en`=0, dwell/blank counters 0, `last`=2 (so source 0 wins first).
- Round-robin pick: search `last+1`, `last+2`, `last` (mod 3); take the first with `req` high.
- IDLE: outputs zero. Any `req` bit high → pick, load `gnt`, `last` := pick, clear dwell counter, go SHOW.
- SHOW: `seg_en`=1. `data`/`point`/`sign` are registered copies of the owner's inputs, refreshed every cycle (live values, not a snapshot). Dwell counter increments 0..DWELL_MAX.
  - Owner `req` drops → BLANK next cycle, regardless of the counter.
  - Counter = DWELL_MAX and another source requesting → BLANK.
  - Counter = DWELL_MAX and no other source requesting → counter wraps to 0; stay in SHOW with the same owner. No blank and no glitch on the outputs.
  - Owner drop and dwell end in the same cycle: treated as a drop.
- BLANK: `gnt`=0, `seg_en`=0, `data`/`point`/`sign`=0. Blank counter increments 0..BLANK_MAX. At BLANK_MAX: pick from the `req` sampled that cycle.
  - A source is found → SHOW with the new owner; this may be the previous owner if it is the only one requesting.
  - No source found → IDLE.
- Requests arriving or dropping during BLANK only matter at the final BLANK cycle.
- Counters are sized to their parameters. Both reset to 0 on every state entry.

## Timing
- Registered outputs. `req` rising in IDLE at edge t → `gnt`, `seg_en`, `data` valid after edge t+1.
- In SHOW, a change on `dataN` appears on `data` one clock later.
- Owner `req` low at edge t → `seg_en`=0 and `gnt`=0 after edge t+1.
- A SHOW slot with contention lasts exactly DWELL_MAX+1 clocks.
- The blank gap lasts exactly BLANK_MAX+1 clocks.
- `gnt` is never multi-hot. `gnt`≠0 exactly when `seg_en`=1.
- `sys_rst` asserted mid-slot: all outputs go to 0 asynchronously. After release, arbitration restarts from IDLE with source 0 having priority.

## Structure
- The shared include holds the state encodings (IDLE=2'd0, SHOW=2'd1, BLANK=2'd2) and the source count 3.
- One sub-module, `seg_arb_pick`: a combinational round-robin picker. Inputs `req[2:0]` and `last[1:0]`; outputs `valid` and `idx[1:0]`.
- FSM, counters and output registers stay in `seg_disp_arbiter`. It is instantiated between the sources and `seg_dynamic` in the display top level.

## Test plan
All scenarios use DWELL_MAX=9, BLANK_MAX=2.
- Reset, then `req`=3'b001 with `data0`=20'd123456, held → `gnt`=001 and `data`=123456 one clock after `req`. `seg_en` stays 1 indefinitely and the SHOW slot repeats with no blank.
- `req`=3'b111 from reset → owners 0,1,2,0,… Each SHOW lasts 10 clocks and each BLANK lasts 3 clocks with `seg_en`=0 and `data`=0.
- Source 1 owns the display; drop `req[1]` at dwell count 4 with `req[2]` high → BLANK starts the next clock, lasts 3 clocks, then `gnt`=100.
- Owner drop coincident with dwell count 9 and no other requests → BLANK for 3 clocks, then IDLE with all outputs 0.
- During SHOW of source 0, step `data0` 5→6→7 on consecutive clocks → `data` shows 5,6,7 each one clock later.
- Assert `sys_rst` mid-SHOW of source 2 → outputs 0 immediately. After release with `req`=3'b101, source 0 is granted first.

Source files
------------

// File: rtl/seg_disp_arbiter_pkg.sv
// Shared types for the seven-segment display arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Holds the arbiter state encoding, the number of sources and a helper
// that turns a source index into a one-hot grant vector.
package seg_disp_arbiter_pkg;

    localparam int NUM_SRC = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } arb_state_t;

    function automatic logic [NUM_SRC-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [NUM_SRC-1:0] oh;
        oh = '0;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/seg_disp_arbiter_pick.sv
// Combinational round-robin picker over three display requesters.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the result is only consumed when the FSM needs a new owner.
// Ports: req[2:0] level requests, last[1:0] previous owner;
//        valid = some source requesting, idx = chosen source.
// Search order starts just after the previous owner and ends with the
// previous owner itself, so a lone requester can win again.
module seg_arb_pick
    import seg_disp_arbiter_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         last,
    output logic               valid,
    output logic [1:0]         idx
);

    logic [1:0] first_c;
    logic [1:0] second_c;
    logic [1:0] third_c;

    always_comb begin
        first_c  = 2'd0;
        second_c = 2'd1;
        third_c  = 2'd2;
        case (last)
            2'd0: begin
                first_c  = 2'd1;
                second_c = 2'd2;
                third_c  = 2'd0;
            end
            2'd1: begin
                first_c  = 2'd2;
                second_c = 2'd0;
                third_c  = 2'd1;
            end
            default: begin
                first_c  = 2'd0;
                second_c = 2'd1;
                third_c  = 2'd2;
            end
        endcase
    end

    always_comb begin
        valid = |req;
        idx   = 2'd0;
        if (req[first_c]) begin
            idx = first_c;
        end else if (req[second_c]) begin
            idx = second_c;
        end else if (req[third_c]) begin
            idx = third_c;
        end
    end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Time-shares one six-digit seven-segment display between three sources.
// Latency: one clock from req/dataN to registered gnt/data/point/sign/seg_en.
// Backpressure: none; a source simply holds req until it has been shown.
// Ports: sys_clk, sys_rst (async, active-high); req[2:0], dataN[19:0],
//        pointN[5:0], signN per source; gnt[2:0] one-hot owner and
//        data/point/sign/seg_en driving seg_dynamic.
module seg_disp_arbiter
    import seg_disp_arbiter_pkg::*;
#(
    parameter logic [25:0] DWELL_MAX = 26'd49_999_999,
    parameter logic [15:0] BLANK_MAX = 16'd4_999
)(
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic [19:0]        data0,
    input  logic [19:0]        data1,
    input  logic [19:0]        data2,
    input  logic [5:0]         point0,
    input  logic [5:0]         point1,
    input  logic [5:0]         point2,
    input  logic               sign0,
    input  logic               sign1,
    input  logic               sign2,
    output logic [NUM_SRC-1:0] gnt,
    output logic [19:0]        data,
    output logic [5:0]         point,
    output logic               sign,
    output logic               seg_en
);

    arb_state_t  state;
    logic [1:0]  last;
    logic [25:0] dwell_cnt;
    logic [15:0] blank_cnt;

    logic        pick_valid;
    logic [1:0]  pick_idx;

    seg_arb_pick u_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // While showing, the owner is 'last'; when taking a new owner the
    // picker result selects which source's inputs get loaded.
    logic [1:0]  sel_idx;
    logic [19:0] sel_data;
    logic [5:0]  sel_point;
    logic        sel_sign;
    logic        owner_req;
    logic        others_req;
    logic        dwell_end;
    logic        blank_end;

    always_comb begin
        sel_idx = (state == SHOW) ? last : pick_idx;
        case (sel_idx)
            2'd1: begin
                sel_data  = data1;
                sel_point = point1;
                sel_sign  = sign1;
            end
            2'd2: begin
                sel_data  = data2;
                sel_point = point2;
                sel_sign  = sign2;
            end
            default: begin
                sel_data  = data0;
                sel_point = point0;
                sel_sign  = sign0;
            end
        endcase
    end

    always_comb begin
        owner_req  = req[last];
        others_req = |(req & ~idx_to_onehot(last));
        dwell_end  = (dwell_cnt == DWELL_MAX);
        blank_end  = (blank_cnt == BLANK_MAX);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            last      <= 2'd2;
            dwell_cnt <= '0;
            blank_cnt <= '0;
            gnt       <= '0;
            data      <= '0;
            point     <= '0;
            sign      <= 1'b0;
            seg_en    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= SHOW;
                        last      <= pick_idx;
                        dwell_cnt <= '0;
                        blank_cnt <= '0;
                        gnt       <= idx_to_onehot(pick_idx);
                        data      <= sel_data;
                        point     <= sel_point;
                        sign      <= sel_sign;
                        seg_en    <= 1'b1;
                    end
                end
                SHOW: begin
                    // A dropped owner request wins over a dwell expiry in the same cycle.
                    if (!owner_req || (dwell_end && others_req)) begin
                        state     <= BLANK;
                        blank_cnt <= '0;
                        dwell_cnt <= '0;
                        gnt       <= '0;
                        data      <= '0;
                        point     <= '0;
                        sign      <= 1'b0;
                        seg_en    <= 1'b0;
                    end else begin
                        // Uncontested expiry just restarts the slot; outputs keep tracking.
                        dwell_cnt <= dwell_end ? '0 : dwell_cnt + 26'd1;
                        data      <= sel_data;
                        point     <= sel_point;
                        sign      <= sel_sign;
                    end
                end
                BLANK: begin
                    if (blank_end) begin
                        blank_cnt <= '0;
                        dwell_cnt <= '0;
                        if (pick_valid) begin
                            state  <= SHOW;
                            last   <= pick_idx;
                            gnt    <= idx_to_onehot(pick_idx);
                            data   <= sel_data;
                            point  <= sel_point;
                            sign   <= sel_sign;
                            seg_en <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        blank_cnt <= blank_cnt + 16'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    dwell_cnt <= '0;
                    blank_cnt <= '0;
                    gnt       <= '0;
                    data      <= '0;
                    point     <= '0;
                    sign      <= 1'b0;
                    seg_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule
